// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine and CPU/DMA external-bus arbiter.
// Optional: define OAM_DMA_BUS_CONFLICT_EN so blocked CPU reads return the byte the DMA is fetching.
module oam_dma_arbiter #(
  parameter int unsigned DMA_LENGTH   = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter int unsigned START_DELAY  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_enable,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_data_out,
  output logic [7:0]  cpu_data_in,
  input  logic [7:0]  io_data_in,
  output logic [15:0] ext_addr,
  output logic        ext_enable,
  output logic        ext_write,
  output logic [7:0]  ext_data_out,
  input  logic [7:0]  ext_data_in,
  output logic [7:0]  oam_addr,
  output logic        oam_write,
  output logic [7:0]  oam_data,
  output logic        dma_active
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_ACTIVE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  idx;
  logic [7:0]  delay;
  logic [7:0]  src;
  logic [7:0]  srcm;
  logic        blocked;
  logic        m_end;
  logic        reg_wr;
  logic        start_done;
  logic        last_xfer;
  logic        cpu_low;

  assign m_end      = (t_cycle == 2'd3);
  assign reg_wr     = cpu_enable & cpu_write & (cpu_addr == DMA_REG_ADDR) & m_end;
  // START lasts START_DELAY M-cycles: the test sees delay before its final decrement to zero.
  assign start_done = (state == S_START) & m_end & (delay <= 8'd1);
  assign last_xfer  = (state == S_ACTIVE) & m_end & (idx == 8'(DMA_LENGTH - 1));
  assign cpu_low    = (cpu_addr < 16'hFF00);
  assign srcm       = (src >= 8'hE0) ? (src - 8'h20) : src;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_START:  if (start_done) state_nxt = S_ACTIVE;
      S_ACTIVE: if (last_xfer)  state_nxt = S_IDLE;
      default:  state_nxt = state;
    endcase
    if (reg_wr) state_nxt = S_START;
  end

  // A register write wins over every other update on the same edge, including the last transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx     <= '0;
      delay   <= '0;
      src     <= '1;
      blocked <= 1'b0;
    end else if (reg_wr) begin
      src   <= cpu_data_out;
      idx   <= '0;
      delay <= 8'(START_DELAY);
    end else if (m_end) begin
      if (state == S_START) begin
        if (delay != '0) delay <= delay - 8'd1;
        if (start_done) blocked <= 1'b1;
      end
      if (state == S_ACTIVE) begin
        if (last_xfer) begin
          idx     <= '0;
          blocked <= 1'b0;
        end else begin
          idx <= idx + 8'd1;
        end
      end
    end
  end

  always_comb begin
    ext_addr     = '0;
    ext_enable   = 1'b0;
    ext_write    = 1'b0;
    ext_data_out = '0;
    oam_write    = 1'b0;
    oam_addr     = idx;
    oam_data     = ext_data_in;
    cpu_data_in  = ext_data_in;
    dma_active   = (state != S_IDLE);

    if (state == S_ACTIVE) begin
      ext_addr   = {srcm, idx};
      ext_enable = 1'b1;
      oam_write  = m_end;
    end else if (cpu_enable && cpu_low && !blocked) begin
      ext_addr     = cpu_addr;
      ext_enable   = 1'b1;
      ext_write    = cpu_write;
      ext_data_out = cpu_data_out;
    end

    if (!cpu_low) begin
      cpu_data_in = (cpu_addr == DMA_REG_ADDR) ? src : io_data_in;
    end else if (blocked) begin
`ifdef OAM_DMA_BUS_CONFLICT_EN
      cpu_data_in = ext_data_in;
`else
      cpu_data_in = 8'hFF;
`endif
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: scoreboard of expected OAM writes plus CPU routing checks.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  t_cycle;
  logic [15:0] cpu_addr;
  logic        cpu_enable;
  logic        cpu_write;
  logic [7:0]  cpu_data_out;
  logic [7:0]  cpu_data_in;
  logic [7:0]  io_data_in;
  logic [15:0] ext_addr;
  logic        ext_enable;
  logic        ext_write;
  logic [7:0]  ext_data_out;
  logic [7:0]  ext_data_in;
  logic [7:0]  oam_addr;
  logic        oam_write;
  logic [7:0]  oam_data;
  logic        dma_active;

  typedef struct {
    logic [7:0]  oa;
    logic [7:0]  od;
    logic [15:0] ea;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   c000_writes = 0;
  logic [7:0] oam [256];

`ifdef OAM_DMA_BUS_CONFLICT_EN
  localparam bit CONFLICT = 1'b1;
`else
  localparam bit CONFLICT = 1'b0;
`endif

  oam_dma_arbiter dut (
    .clk(clk), .reset_n(reset_n), .t_cycle(t_cycle),
    .cpu_addr(cpu_addr), .cpu_enable(cpu_enable), .cpu_write(cpu_write),
    .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in), .io_data_in(io_data_in),
    .ext_addr(ext_addr), .ext_enable(ext_enable), .ext_write(ext_write),
    .ext_data_out(ext_data_out), .ext_data_in(ext_data_in),
    .oam_addr(oam_addr), .oam_write(oam_write), .oam_data(oam_data),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  // External memory contents as a fixed pattern per page.
  function automatic logic [7:0] pat(input logic [15:0] a);
    case (a[15:8])
      8'hC1:   pat = a[7:0] ^ 8'h5A;
      8'hD0:   pat = a[7:0] ^ 8'hA5;
      8'hC3:   pat = a[7:0] ^ 8'h33;
      default: pat = a[7:0] ^ a[15:8] ^ 8'h96;
    endcase
  endfunction

  function automatic logic [7:0] blk_rd(input logic [15:0] a);
    blk_rd = CONFLICT ? pat(a) : 8'hFF;
  endfunction

  assign ext_data_in = pat(ext_addr);

  always @(posedge clk) begin
    if (oam_write) oam[oam_addr] <= oam_data;
    if (ext_enable && ext_write && ext_addr == 16'hC000) c000_writes <= c000_writes + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    t_cycle = t_cycle + 2'd1;
  endtask

  task automatic push_range(input logic [7:0] s, input int n);
    logic [7:0] m;
    exp_t e;
    m = (s >= 8'hE0) ? s - 8'h20 : s;
    for (int i = 0; i < n; i++) begin
      e.oa = 8'(i);
      e.ea = {m, 8'(i)};
      e.od = pat(e.ea);
      sb.push_back(e);
    end
  endtask

  // One M-cycle: pops the scoreboard on every OAM strobe, optional CPU-read and ext-bus checks at t=1.
  task automatic mcyc(input bit rd_chk, input logic [7:0] exp_rd,
                      input bit ext_chk, input logic exp_en, input logic [15:0] exp_addr);
    exp_t e;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (oam_write) begin
        pulses++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL oam_unexpected: got addr %h data %h, expected no write", oam_addr, oam_data);
        end else begin
          e = sb.pop_front();
          if (oam_addr !== e.oa || oam_data !== e.od || ext_addr !== e.ea ||
              ext_enable !== 1'b1 || ext_write !== 1'b0) begin
            errors++;
            $display("FAIL oam_xfer: got oa=%h od=%h ea=%h en=%b we=%b, expected oa=%h od=%h ea=%h en=1 we=0",
                     oam_addr, oam_data, ext_addr, ext_enable, ext_write, e.oa, e.od, e.ea);
          end
        end
      end
      if (rd_chk && t == 1) begin
        checks++;
        if (cpu_data_in !== exp_rd) begin
          errors++;
          $display("FAIL cpu_read %h: got %h expected %h", cpu_addr, cpu_data_in, exp_rd);
        end
      end
      if (ext_chk && t == 1) begin
        checks++;
        if (ext_enable !== exp_en || ext_write !== 1'b0 || ext_addr !== exp_addr) begin
          errors++;
          $display("FAIL ext_bus: got en=%b we=%b addr=%h expected en=%b we=0 addr=%h",
                   ext_enable, ext_write, ext_addr, exp_en, exp_addr);
        end
      end
      cyc();
    end
  endtask

  task automatic reg_write(input logic [7:0] v);
    cpu_enable = 1'b1; cpu_write = 1'b1; cpu_addr = 16'hFF46; cpu_data_out = v;
    mcyc(0, 8'h00, 0, 1'b0, 16'h0000);
    cpu_enable = 1'b0; cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_data_out = 8'h00;
  endtask

  task automatic cpu_set(input logic en, input logic we, input logic [15:0] a, input logic [7:0] d);
    cpu_enable = en; cpu_write = we; cpu_addr = a; cpu_data_out = d;
  endtask

  task automatic check_end(input string name, input int exp_pulses);
    checks++;
    if (dma_active !== 1'b0 || pulses !== exp_pulses || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_end: got active=%b pulses=%0d pending=%0d expected active=0 pulses=%0d pending=0",
               name, dma_active, pulses, sb.size(), exp_pulses);
    end
  endtask

  task automatic test_reset();
    cpu_set(1'b0, 1'b0, 16'hFF46, 8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (dma_active !== 1'b0 || oam_write !== 1'b0 || ext_enable !== 1'b0 || cpu_data_in !== 8'hFF) begin
      errors++;
      $display("FAIL reset_state: got active=%b ow=%b en=%b src=%h expected 0 0 0 ff",
               dma_active, oam_write, ext_enable, cpu_data_in);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    cpu_set(1'b0, 1'b0, 16'hC123, 8'h00);
    @(negedge clk);
    checks++;
    if (ext_enable !== 1'b0 || ext_addr !== 16'h0000 || ext_data_out !== 8'h00) begin
      errors++;
      $display("FAIL idle_bus: got en=%b addr=%h dout=%h expected 0 0000 00", ext_enable, ext_addr, ext_data_out);
    end
    cpu_set(1'b1, 1'b1, 16'h1234, 8'hAB);
    @(negedge clk);
    checks++;
    if (ext_enable !== 1'b1 || ext_write !== 1'b1 || ext_addr !== 16'h1234 || ext_data_out !== 8'hAB) begin
      errors++;
      $display("FAIL pass_write: got en=%b we=%b addr=%h dout=%h expected 1 1 1234 ab",
               ext_enable, ext_write, ext_addr, ext_data_out);
    end
    cpu_set(1'b1, 1'b0, 16'h4567, 8'h00);
    @(negedge clk);
    checks++;
    if (cpu_data_in !== pat(16'h4567) || ext_write !== 1'b0) begin
      errors++;
      $display("FAIL pass_read: got %h we=%b expected %h we=0", cpu_data_in, ext_write, pat(16'h4567));
    end
    cpu_set(1'b1, 1'b1, 16'hFF80, 8'h12);
    io_data_in = 8'h5E;
    @(negedge clk);
    checks++;
    if (cpu_data_in !== 8'h5E || ext_enable !== 1'b0) begin
      errors++;
      $display("FAIL io_idle: got %h en=%b expected 5e en=0", cpu_data_in, ext_enable);
    end
    cpu_set(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic test_transfer();
    int p0;
    p0 = pulses;
    push_range(8'hC1, 160);
    reg_write(8'hC1);
    mcyc(0, 8'h00, 0, 1'b0, 16'h0000);
    checks++;
    if (pulses !== p0 || dma_active !== 1'b1) begin
      errors++;
      $display("FAIL start_phase: got pulses=%0d active=%b expected %0d 1", pulses - p0, dma_active, 0);
    end
    mcyc(0, 8'h00, 0, 1'b0, 16'h0000);
    checks++;
    if (pulses !== p0 + 1) begin
      errors++;
      $display("FAIL first_xfer_m2: got %0d pulses expected 1", pulses - p0);
    end
    repeat (159) mcyc(0, 8'h00, 0, 1'b0, 16'h0000);
    check_end("transfer", p0 + 160);
    for (int i = 0; i < 160; i++) begin
      checks++;
      if (oam[i] !== (8'(i) ^ 8'h5A)) begin
        errors++;
        $display("FAIL oam_content[%0d]: got %h expected %h", i, oam[i], 8'(i) ^ 8'h5A);
      end
    end
  endtask

  task automatic test_blocked();
    int p0;
    p0 = pulses;
    push_range(8'hC1, 160);
    reg_write(8'hC1);
    repeat (11) mcyc(0, 8'h00, 0, 1'b0, 16'h0000);
    cpu_set(1'b1, 1'b0, 16'hC000, 8'h00);
    mcyc(1, blk_rd(16'hC10A), 1, 1'b1, 16'hC10A);
    cpu_set(1'b1, 1'b1, 16'hC000, 8'h77);
    mcyc(0, 8'h00, 1, 1'b1, 16'hC10B);
    io_data_in = 8'h3C;
    cpu_set(1'b1, 1'b0, 16'hFF80, 8'h00);
    mcyc(1, 8'h3C, 1, 1'b1, 16'hC10C);
    cpu_set(1'b1, 1'b1, 16'hFF80, 8'h99);
    mcyc(0, 8'h00, 1, 1'b1, 16'hC10D);
    cpu_set(1'b1, 1'b0, 16'hFF46, 8'h00);
    mcyc(1, 8'hC1, 1, 1'b1, 16'hC10E);
    cpu_set(1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (145) mcyc(0, 8'h00, 0, 1'b0, 16'h0000);
    check_end("blocked", p0 + 160);
    checks++;
    if (c000_writes !== 0) begin
      errors++;
      $display("FAIL blocked_write: got %0d writes to c000 expected 0", c000_writes);
    end
  endtask

  task automatic test_restart();
    int p0;
    p0 = pulses;
    push_range(8'hC1, 51);
    push_range(8'hD0, 160);
    reg_write(8'hC1);
    repeat (51) mcyc(0, 8'h00, 0, 1'b0, 16'h0000);
    reg_write(8'hD0);
    cpu_set(1'b1, 1'b0, 16'hC000, 8'h00);
    mcyc(1, blk_rd(16'h0000), 1, 1'b0, 16'h0000);
    cpu_set(1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (160) mcyc(0, 8'h00, 0, 1'b0, 16'h0000);
    check_end("restart", p0 + 211);
  endtask

  task automatic test_echo();
    int p0;
    p0 = pulses;
    push_range(8'hE3, 160);
    reg_write(8'hE3);
    repeat (161) mcyc(0, 8'h00, 0, 1'b0, 16'h0000);
    check_end("echo", p0 + 160);
  endtask

  task automatic test_reset_mid();
    int p0;
    p0 = pulses;
    push_range(8'hC1, 80);
    reg_write(8'hC1);
    repeat (81) mcyc(0, 8'h00, 0, 1'b0, 16'h0000);
    repeat (3) cyc();
    @(negedge clk);
    checks++;
    if (oam_write !== 1'b1 || oam_addr !== 8'd80) begin
      errors++;
      $display("FAIL pre_abort: got ow=%b idx=%h expected 1 50", oam_write, oam_addr);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (oam_write !== 1'b0 || dma_active !== 1'b0) begin
      errors++;
      $display("FAIL abort: got ow=%b active=%b expected 0 0", oam_write, dma_active);
    end
    cyc();
    repeat (2) mcyc(0, 8'h00, 0, 1'b0, 16'h0000);
    reset_n = 1'b1;
    cpu_set(1'b1, 1'b0, 16'h2000, 8'h00);
    mcyc(1, pat(16'h2000), 1, 1'b1, 16'h2000);
    cpu_set(1'b0, 1'b0, 16'h0000, 8'h00);
    check_end("reset_mid", p0 + 80);
  endtask

  initial begin
    reset_n = 1'b0;
    t_cycle = 2'd0;
    cpu_addr = 16'h0000;
    cpu_enable = 1'b0;
    cpu_write = 1'b0;
    cpu_data_out = 8'h00;
    io_data_in = 8'h00;
    test_reset();
    test_transfer();
    test_blocked();
    test_restart();
    test_echo();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
